// File: rtl/cpu_pkg.sv
// Shared types, defaults and jump evaluation for the Hack-style CPU sequencer.
package cpu_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned AW_DEF = 15;
  localparam logic [AW_DEF-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    DECODE   = 2'd1,
    EXEC     = 2'd2,
    MEM_WAIT = 2'd3
  } cpu_state_e;

  // Jump condition from the three j bits and the ALU flags; j=111 is unconditional.
  function automatic logic jump_taken(input logic j1, input logic j2, input logic j3,
                                      input logic zr, input logic ng);
    return (j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: synchronous reset, absolute load, or wrapping increment.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [AW-1:0] i_load_val,
  input  logic          i_inc,
  output logic [AW-1:0] o_pc
);

  logic [AW-1:0] r_pc;

  // Load wins over increment; the increment naturally wraps at 2^AW.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= AW'(RESET_PC);
    end else if (i_load) begin
      r_pc <= i_load_val;
    end else if (i_inc) begin
      r_pc <= r_pc + AW'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Fetch/decode/execute sequencer: owns PC and instruction register, drives
// A/D load strobes and the data-memory write handshake.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic [DW-1:0] instr_q,
  input  logic          instr_type,
  input  logic          cmd_d1,
  input  logic          cmd_d2,
  input  logic          cmd_d3,
  input  logic          cmd_j1,
  input  logic          cmd_j2,
  input  logic          cmd_j3,
  input  logic          alu_zr,
  input  logic          alu_ng,
  input  logic [DW-1:0] a_q,
  output logic          a_sel_imm,
  output logic          a_load,
  output logic          d_load,
  output logic          dmem_we,
  input  logic          dmem_ack,
  output logic [AW-1:0] pc,
  output logic          busy_mem
);

  cpu_state_e    r_state;
  cpu_state_e    w_next;
  logic [DW-1:0] r_instr_q;
  logic          r_imem_req;
  logic          r_a_load;
  logic          r_a_sel_imm;
  logic          r_d_load;
  logic          r_dmem_we;
  logic          r_busy_mem;

  logic          w_imem_req_nxt;
  logic          w_a_load_nxt;
  logic          w_a_sel_imm_nxt;
  logic          w_d_load_nxt;
  logic          w_dmem_we_nxt;
  logic          w_instr_load;
  logic          w_pc_load;
  logic          w_pc_inc;
  logic          w_take;
  logic [AW-1:0] w_pc;
  logic          w_unused_a_q;

  // Upper A bits beyond the PC width never reach the PC.
  assign w_unused_a_q = ^a_q;

  // A-instructions never jump, whatever their low bits look like.
  assign w_take = instr_type & jump_taken(cmd_j1, cmd_j2, cmd_j3, alu_zr, alu_ng);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, register enables and next values of the registered outputs.
  always_comb begin
    w_next          = r_state;
    w_imem_req_nxt  = 1'b0;
    w_a_load_nxt    = 1'b0;
    w_a_sel_imm_nxt = 1'b0;
    w_d_load_nxt    = 1'b0;
    w_dmem_we_nxt   = 1'b0;
    w_instr_load    = 1'b0;
    w_pc_load       = 1'b0;
    w_pc_inc        = 1'b0;

    case (r_state)
      FETCH: begin
        // Only an ack against an issued request completes the fetch.
        if (r_imem_req && imem_ack) begin
          w_instr_load = 1'b1;
          w_next       = DECODE;
        end
      end
      DECODE: begin
        w_next = EXEC;
      end
      EXEC: begin
        if (w_take) begin
          w_pc_load = 1'b1;
        end else begin
          w_pc_inc = 1'b1;
        end
        w_next = (instr_type && cmd_d3) ? MEM_WAIT : FETCH;
      end
      MEM_WAIT: begin
        if (r_dmem_we && dmem_ack) begin
          w_next = FETCH;
        end
      end
      default: begin
        w_next = FETCH;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    w_imem_req_nxt = (w_next == FETCH);
    w_dmem_we_nxt  = (w_next == MEM_WAIT);

    // Demux outputs are already settled from instr_q during DECODE, so the
    // EXEC strobes can be registered one cycle early.
    if (r_state == DECODE) begin
      w_a_load_nxt    = instr_type ? cmd_d1 : 1'b1;
      w_a_sel_imm_nxt = ~instr_type;
      w_d_load_nxt    = instr_type & cmd_d2;
    end
  end

  // Instruction register and registered strobes/requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_q   <= '0;
      r_imem_req  <= 1'b0;
      r_a_load    <= 1'b0;
      r_a_sel_imm <= 1'b0;
      r_d_load    <= 1'b0;
      r_dmem_we   <= 1'b0;
      r_busy_mem  <= 1'b0;
    end else begin
      if (w_instr_load) begin
        r_instr_q <= imem_rdata;
      end
      r_imem_req  <= w_imem_req_nxt;
      r_a_load    <= w_a_load_nxt;
      r_a_sel_imm <= w_a_sel_imm_nxt;
      r_d_load    <= w_d_load_nxt;
      r_dmem_we   <= w_dmem_we_nxt;
      r_busy_mem  <= w_dmem_we_nxt;
    end
  end

  pc_reg #(
    .AW (AW)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_pc_load),
    .i_load_val (a_q[AW-1:0]),
    .i_inc      (w_pc_inc),
    .o_pc       (w_pc)
  );

  assign imem_req  = r_imem_req;
  assign imem_addr = w_pc;
  assign pc        = w_pc;
  assign instr_q   = r_instr_q;
  assign a_load    = r_a_load;
  assign a_sel_imm = r_a_sel_imm;
  assign d_load    = r_d_load;
  assign dmem_we   = r_dmem_we;
  assign busy_mem  = r_busy_mem;

endmodule
